data_mem_access_unit: RTL and testbench

//  Memory-side responder for the decoder's MemEn/MemWrite/MemToReg signals. Turns a single-cycle

---
 rtl/data_mem_access_pkg.sv | 40 ++++
 rtl/data_mem_access_unit_tmo.sv | 41 ++++
 rtl/data_mem_access_unit.sv | 187 ++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_access_pkg.sv
// data_mem_access_pkg
//   Shared types and constants for the data memory access unit.
//   - state_e     : 2-bit access FSM state encoding
//   - TMO_W       : width of the bus timeout counter
//   - WEN_*       : byte-strobe patterns that carry alignment rules
//   - is_misaligned() : alignment rule for a strobe pattern, used only
//     when the design is built with MEM_ALIGN_CHECK_EN defined.
package data_mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int TMO_W = 8;

  localparam logic [3:0] WEN_LOAD    = 4'b0000;
  localparam logic [3:0] WEN_WORD    = 4'b1111;
  localparam logic [3:0] WEN_HALF_LO = 4'b0011;
  localparam logic [3:0] WEN_HALF_HI = 4'b1100;

  // Word accesses (loads are treated as words) need addr[1:0]==0,
  // halfword stores need addr[0]==0; byte and other patterns are never
  // rejected.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [3:0] wen);
    logic bad;
    if ((wen == WEN_LOAD) || (wen == WEN_WORD)) begin
      bad = (addr_lo != 2'b00);
    end else if ((wen == WEN_HALF_LO) || (wen == WEN_HALF_HI)) begin
      bad = addr_lo[0];
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_access_unit_tmo.sv
// data_mem_tmo_ctr
//   Bus wait timeout counter: clear has priority over enable, and the
//   terminal-count flag fires during the LIMIT-th enabled cycle so the
//   owner can leave its wait state on that same edge.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (state entry)
//   en       : count this cycle (waiting on the bus)
//   tc       : this is the last allowed waiting cycle
module data_mem_tmo_ctr
  import data_mem_access_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] count_r;

  // Wait-cycle counter with clear priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TMO_W{1'b0}};
    end else if (clr) begin
      count_r <= {TMO_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = en && (count_r == LAST);

endmodule

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
//   Turns a one-cycle load/store request from the MEM stage into a
//   req/addr_ok/data_ok bus transaction, stalling the pipeline until the
//   access completes or times out.
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   mem_en/mem_wen     : request strobe and byte write enables (0 = load)
//   mem_addr/mem_wdata : request address and store data
//   mem_rdata          : load data, valid while mem_done=1, held otherwise
//   mem_stall          : freeze upstream (combinational on mem_en in IDLE)
//   mem_done/mem_err   : one-cycle completion pulse / error flag
//   bus_req..bus_wdata : bus request channel, stable until bus_addr_ok
//   bus_addr_ok        : request accepted
//   bus_data_ok        : read data / write ack, with bus_rdata
// Configuration
//   MEM_ALIGN_CHECK_EN : when defined, misaligned requests complete with
//                        mem_err without touching the bus.
module data_mem_access_unit
  import data_mem_access_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic [DATA_W/8-1:0]   mem_wen,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_stall,
  output logic                  mem_done,
  output logic                  mem_err,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_r;
  state_e              state_next_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wen_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                err_r;
  logic                err_next_s;
  logic                capture_s;
  logic                misalign_s;
  logic                tmo_en_s;
  logic                tmo_clr_s;
  logic                tmo_tc_s;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = is_misaligned(mem_addr[1:0], mem_wen);
`else
  assign misalign_s = 1'b0;
`endif

  assign tmo_en_s  = (state_r == ST_REQ) || (state_r == ST_RESP);
  // Clearing on every state change restarts the budget for each phase.
  assign tmo_clr_s = (state_next_s != state_r);

  data_mem_tmo_ctr #(
    .LIMIT (TMO_CYC)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr_s),
    .en  (tmo_en_s),
    .tc  (tmo_tc_s)
  );

  // Next-state logic; a bus response always wins over a coincident timeout.
  always_comb begin
    state_next_s = state_r;
    err_next_s   = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_en) begin
          if (misalign_s) begin
            state_next_s = ST_DONE;
            err_next_s   = 1'b1;
          end else begin
            state_next_s = ST_REQ;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            state_next_s = ST_DONE;
            capture_s    = 1'b1;
          end else begin
            state_next_s = ST_RESP;
          end
        end else if (tmo_tc_s) begin
          state_next_s = ST_DONE;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (bus_data_ok) begin
          state_next_s = ST_DONE;
          capture_s    = 1'b1;
        end else if (tmo_tc_s) begin
          state_next_s = ST_DONE;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latches, loaded only when a new access is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      wen_r   <= {STRB_W{1'b0}};
    end else if ((state_r == ST_IDLE) && mem_en) begin
      addr_r  <= mem_addr;
      wdata_r <= mem_wdata;
      wen_r   <= mem_wen;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wen_r   <= wen_r;
    end
  end

  // Completion data and error flag; err_r is high only during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      err_r <= err_next_s;
      if (err_next_s) begin
        rdata_r <= {DATA_W{1'b0}};
      end else if (capture_s && (wen_r == {STRB_W{1'b0}})) begin
        rdata_r <= bus_rdata;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign mem_rdata = rdata_r;
  assign mem_done  = (state_r == ST_DONE);
  assign mem_err   = err_r;
  assign mem_stall = tmo_en_s || ((state_r == ST_IDLE) && mem_en);
  assign bus_req   = (state_r == ST_REQ);
  assign bus_wr    = |wen_r;
  assign bus_wstrb = wen_r;
  assign bus_addr  = addr_r;
  assign bus_wdata = wdata_r;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: the driver pushes the
// expected completion of every access, a bus responder plays the slave
// side with chosen latencies, and a monitor checks each mem_done.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_done;
  logic        mem_err;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wen;
    int          a_dly;
    int          d_dly;
  } cfg_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  cfg_t        cfg_q[$];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          bus_auto = 1'b0;
  logic [31:0] last_rd = 32'h0;

  data_mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en      (mem_en),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_stall   (mem_stall),
    .mem_done    (mem_done),
    .mem_err     (mem_err),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_wstrb   (bus_wstrb),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  function automatic bit tb_misaligned(input logic [31:0] a, input logic [3:0] w);
    if ((w == 4'h0 || w == 4'hF) && a[1:0] != 2'b00) return 1'b1;
    if ((w == 4'h3 || w == 4'hC) && a[0]) return 1'b1;
    return 1'b0;
  endfunction
`endif

  // Request channel must match the issued access while bus_req is up.
  task automatic check_req(input cfg_t c);
    check(bus_addr === c.addr, "req_addr", bus_addr, c.addr);
    check(bus_wr === (c.wen != 4'h0), "req_wr", {31'h0, bus_wr}, {31'h0, (c.wen != 4'h0)});
    check(bus_wstrb === c.wen, "req_wstrb", {28'h0, bus_wstrb}, {28'h0, c.wen});
    check(bus_wdata === c.wdata, "req_wdata", bus_wdata, c.wdata);
  endtask

  // Issue one access (entered just after a posedge), wait for its done.
  task automatic do_access(input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wdata, input int a, input int d,
                           input logic [31:0] rd, input int gap);
    bit   mis;
    bit   err;
    cfg_t c;
    exp_t e;
    int   n;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = tb_misaligned(addr, wen);
`endif
    if (!mis) begin
      c.addr = addr; c.wdata = wdata; c.rdata = rd; c.wen = wen;
      c.a_dly = a; c.d_dly = d;
      cfg_q.push_back(c);
    end
    // Address wait budget is 255 cycles, data wait budget 255 cycles
    // after the accept; a response in the last allowed cycle still counts.
    err = mis || (a >= 255) || (d >= 256);
    if (err) begin
      e.rdata = 32'h0;
      last_rd = 32'h0;
    end else if (wen == 4'h0) begin
      e.rdata = rd;
      last_rd = rd;
    end else begin
      e.rdata = last_rd;
    end
    e.err = err;
    exp_q.push_back(e);

    mem_en = 1'b1; mem_addr = addr; mem_wen = wen; mem_wdata = wdata;
    @(negedge clk);
    check(mem_stall === 1'b1, "stall_issue", {31'h0, mem_stall}, 32'h1);
    @(posedge clk); #1;
    mem_en = 1'b0; mem_addr = $urandom; mem_wen = 4'($urandom); mem_wdata = $urandom;
    @(negedge clk);
    if (!mis) check(bus_req === 1'b1, "req_latency", {31'h0, bus_req}, 32'h1);
    n = 0;
    while (!mem_done && n < 700) begin
      check(mem_stall === 1'b1, "stall_busy", {31'h0, mem_stall}, 32'h1);
      @(negedge clk);
      n++;
    end
    if (!mem_done) check(1'b0, "done_timeout", 32'(n), 32'd700);
    @(posedge clk); #1;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor: every completion must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mem_done) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", {31'h0, mem_done}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check(mem_rdata === e.rdata, "done_rdata", mem_rdata, e.rdata);
        check(mem_err === e.err, "done_err", {31'h0, mem_err}, {31'h0, e.err});
        check(mem_stall === 1'b0, "done_stall", {31'h0, mem_stall}, 32'h0);
        check(bus_req === 1'b0, "done_req", {31'h0, bus_req}, 32'h0);
      end
    end
  end

  // Bus slave model driven by the per-access latency table.
  initial begin
    cfg_t c;
    int   n;
    int   m;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (bus_auto && bus_req) begin
        if (cfg_q.size() == 0) begin
          check(1'b0, "unexpected_req", bus_addr, 32'h0);
        end else begin
          c = cfg_q.pop_front();
          n = 0;
          while (bus_req && n < c.a_dly) begin
            check_req(c);
            @(posedge clk); #1;
            n++;
          end
          if (!bus_req) begin
            check(n == 255, "req_cycles_tmo", 32'(n), 32'd255);
          end else begin
            check_req(c);
            bus_addr_ok = 1'b1;
            if (c.d_dly == 0) begin
              bus_data_ok = 1'b1; bus_rdata = c.rdata;
            end
            @(posedge clk); #1;
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
            check(bus_req === 1'b0, "req_drop", {31'h0, bus_req}, 32'h0);
            if (c.d_dly != 0) begin
              m = 1;
              while (!mem_done && m < c.d_dly) begin
                @(posedge clk); #1;
                m++;
              end
              if (!mem_done) begin
                bus_data_ok = 1'b1; bus_rdata = c.rdata;
                @(posedge clk); #1;
                bus_data_ok = 1'b0; bus_rdata = $urandom;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=%0d required=%0d", total, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  pats [8];
    logic [3:0]  w;
    logic [31:0] ad;
    pats[0] = 4'h0; pats[1] = 4'hF; pats[2] = 4'h3; pats[3] = 4'hC;
    pats[4] = 4'h1; pats[5] = 4'h2; pats[6] = 4'h4; pats[7] = 4'h8;
    rst = 1'b1; mem_en = 1'b0; mem_wen = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({mem_rdata, mem_stall, mem_done, mem_err, bus_req, bus_wr} === 37'h0,
          "reset_mem", mem_rdata, 32'h0);
    check({bus_wstrb, bus_addr, bus_wdata} === 68'h0, "reset_bus", bus_addr, 32'h0);

    // Reset while waiting for data, then a stray data_ok.
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; mem_en = 1'b1; mem_addr = 32'h300; mem_wen = 4'h0; mem_wdata = 32'h5;
    @(negedge clk);
    check(mem_stall === 1'b1, "rst_t_stall", {31'h0, mem_stall}, 32'h1);
    @(posedge clk); #1; mem_en = 1'b0;
    @(negedge clk);
    check(bus_req === 1'b1, "rst_t_req", {31'h0, bus_req}, 32'h1);
    @(posedge clk); #1; bus_addr_ok = 1'b1;
    @(posedge clk); #1; bus_addr_ok = 1'b0;
    @(negedge clk);
    check({bus_req, mem_stall} === 2'b01, "rst_t_resp", {30'h0, bus_req, mem_stall}, 32'h1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA5555;
    @(negedge clk);
    check({mem_done, mem_err, mem_stall, bus_req} === 4'h0, "rst_t_flags",
          {28'h0, mem_done, mem_err, mem_stall, bus_req}, 32'h0);
    check(mem_rdata === 32'h0, "rst_t_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1; bus_data_ok = 1'b0;
    @(negedge clk);
    check({mem_done, mem_err} === 2'b00, "rst_t_stray", {30'h0, mem_done, mem_err}, 32'h0);
    check(mem_rdata === 32'h0, "rst_t_rdata2", mem_rdata, 32'h0);

    bus_auto = 1'b1;
    @(posedge clk); #1;
    do_access(32'h100, 4'h0, 32'h11, 0, 1, 32'hDEADBEEF, 0);
    do_access(32'h204, 4'hF, 32'h12345678, 3, 2, 32'h77, 0);
    do_access(32'h208, 4'h0, 32'h0, 1, 0, 32'h0BADF00D, 1);
    do_access(32'h040, 4'h0, 32'h0, 400, 1, 32'h99, 0);
    do_access(32'h044, 4'hF, 32'hCAFE, 0, 300, 32'h98, 0);
    do_access(32'h048, 4'h3, 32'h1234, 2, 2, 32'h97, 0);
    do_access(32'h050, 4'h0, 32'h0, 0, 255, 32'h600DF00D, 0);
    do_access(32'h102, 4'h0, 32'h0, 1, 1, 32'hFEEDFACE, 0);

    for (int i = 0; i < 40; i++) begin
      w  = pats[$urandom_range(0, 7)];
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
      do_access(ad, w, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom, $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "exp_q_empty", 32'(exp_q.size()), 32'h0);
    check(cfg_q.size() == 0, "cfg_q_empty", 32'(cfg_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
